bt_uart_tx_fifo: RTL

//  UART transmitter with a byte FIFO. It drives the RN4871 RXD pin (FPGA -> Bluetooth).
//  It is the counterpart of the UART receiver that listens on the RN4871 TXD pin.

---
 rtl/bt_uart_tx_fifo_if.sv | 33 +++
 rtl/bt_uart_tx_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bt_uart_tx_fifo_if.sv
//------------------------------------------------------------------------------
// Module      : bt_uart_tx_fifo_if
// Description : Byte-queue and serial-line signal bundle for bt_uart_tx_fifo.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface bt_uart_tx_fifo_if #(
    parameter int FIFO_DEPTH_LOG2 = 4
);
    logic                       i_TX_DV;
    logic [7:0]                 i_TX_Byte;
    logic                       o_Full;
    logic                       o_Empty;
    logic [FIFO_DEPTH_LOG2:0]   o_Count;
    logic                       o_Overflow;
    logic                       o_TX_Serial;
    logic                       o_TX_Active;
    logic                       o_TX_Done;

    modport master (
        output i_TX_DV, i_TX_Byte,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_Serial, o_TX_Active, o_TX_Done
    );

    modport slave (
        input  i_TX_DV, i_TX_Byte,
        output o_Full, o_Empty, o_Count, o_Overflow, o_TX_Serial, o_TX_Active, o_TX_Done
    );
endinterface

`default_nettype wire

// File: rtl/bt_uart_tx_fifo.sv
//------------------------------------------------------------------------------
// Module      : bt_uart_tx_fifo
// Description : 8N1 UART transmitter fed by a byte FIFO (FPGA -> RN4871 RXD).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module bt_uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 217,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  wire logic           i_Clk,
    input  wire logic           i_Rst_L,
    bt_uart_tx_fifo_if.slave    tx_if
);
    localparam int                     DEPTH   = 2 ** FIFO_DEPTH_LOG2;
    localparam int                     CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]       C_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] C_DEPTH = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]                 mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic                       full_q, empty_q, ovf_q;

    state_t                     state_q;
    logic [CNT_W-1:0]           clk_cnt_q;
    logic [2:0]                 bit_idx_q;
    logic [7:0]                 shift_q;
    logic                       serial_q, active_q, done_q;

    logic                       w_push, w_drop, w_pop;
    logic [2:0]                 w_next_idx;

    // Room is judged on the registered flag only, so a same-edge pop never admits a write.
    assign w_push     = tx_if.i_TX_DV &&  !full_q;
    assign w_drop     = tx_if.i_TX_DV &&   full_q;
    assign w_pop      = (state_q == S_IDLE) && !empty_q;
    assign w_next_idx = bit_idx_q + 3'd1;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= tx_if.i_TX_Byte;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == C_DEPTH);
            empty_q <= (count_d == '0);
            ovf_q   <= w_drop;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    serial_q  <= 1'b1;
                    active_q  <= 1'b0;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (w_pop) begin
                        shift_q  <= mem_q[rd_ptr_q];
                        serial_q <= 1'b0;
                        active_q <= 1'b1;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (clk_cnt_q == C_LAST) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        serial_q  <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == C_LAST) begin
                        clk_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            serial_q <= 1'b1;
                            state_q  <= S_STOP;
                        end else begin
                            bit_idx_q <= w_next_idx;
                            serial_q  <= shift_q[w_next_idx];
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt_q == C_LAST) begin
                        clk_cnt_q <= '0;
                        active_q  <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_if.o_Full      = full_q;
    assign tx_if.o_Empty     = empty_q;
    assign tx_if.o_Count     = count_q;
    assign tx_if.o_Overflow  = ovf_q;
    assign tx_if.o_TX_Serial = serial_q;
    assign tx_if.o_TX_Active = active_q;
    assign tx_if.o_TX_Done   = done_q;

endmodule

`default_nettype wire
